// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute sequencer for the 32-bit RISC datapath.
// Optional single-step mode: define CONTROL_SEQUENCER_STEP_EN (adds Step in / Paused out).
module control_sequencer #(
  parameter int         MEM_WAIT = 0,
  parameter logic [4:0] OP_INC   = 5'b11111,
  parameter logic [4:0] OP_ADD   = 5'b00011
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  input  logic        Stop,
`ifdef CONTROL_SEQUENCER_STEP_EN
  input  logic        Step,
  output logic        Paused,
`endif
  output logic        Run,
  output logic        PCout, PCin, MARin, MDRin, MDRout, Read, Write, IRin,
  output logic        Yin, Zin, Zlowout, Zhighout, HIin, HIout, LOin, LOout,
  output logic        Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONin, OutportIn, InPortOut,
  output logic [4:0]  OpCode
);
  localparam int WW = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;

  typedef enum logic [3:0] {
    RESET, T0, T1, T2, T3, T4, T5, T6, T7, HALTED, PAUSED
  } state_t;

  state_t          state_q, state_d;
  logic [4:0]      op_q;
  logic [WW-1:0]   wcnt;
  logic            stop_q, last, first, wdone;
  state_t          bnd_next;
  logic            unused_ir;

  assign unused_ir = ^IR[26:0];
  assign first     = (wcnt == WW'(MEM_WAIT));
  assign wdone     = (wcnt == '0);

  // A Stop pulse is remembered so the current instruction still finishes.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= RESET;
      op_q    <= '0;
      wcnt    <= WW'(MEM_WAIT);
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (Stop) stop_q <= 1'b1;
      if (state_q == T2) op_q <= IR[31:27];
      if (state_d != state_q) wcnt <= WW'(MEM_WAIT);
      else if (!wdone)        wcnt <= wcnt - 1'b1;
    end
  end

  wire is_alu = (op_q >= 5'd3)  && (op_q <= 5'd11);
  wire is_imm = (op_q >= 5'd12) && (op_q <= 5'd14);
  wire is_md  = (op_q == 5'd15) || (op_q == 5'd16);
  wire is_neg = (op_q == 5'd17) || (op_q == 5'd18);
  wire is_mem = (op_q <= 5'd2);

  always_comb begin
`ifdef CONTROL_SEQUENCER_STEP_EN
    bnd_next = (Stop || stop_q) ? HALTED : PAUSED;
`else
    bnd_next = (Stop || stop_q) ? HALTED : T0;
`endif
  end

  always_comb begin
    state_d = state_q;
    last    = 1'b0;
    Run     = !(state_q == RESET || state_q == HALTED);
    {PCout, PCin, MARin, MDRin, MDRout, Read, Write, IRin} = '0;
    {Yin, Zin, Zlowout, Zhighout, HIin, HIout, LOin, LOout} = '0;
    {Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONin, OutportIn, InPortOut} = '0;
    OpCode  = '0;
`ifdef CONTROL_SEQUENCER_STEP_EN
    Paused  = (state_q == PAUSED);
`endif
    case (state_q)
      RESET: state_d = T0;
      T0: begin
        {PCout, MARin, Zin} = '1; OpCode = OP_INC; state_d = T1;
      end
      T1: begin
        {Zlowout, PCin} = {2{first}};
        {Read, MDRin} = '1;
        if (wdone) state_d = T2;
      end
      T2: begin
        {MDRout, IRin} = '1; state_d = T3;
      end
      T3: begin
        state_d = T4;
        if (is_alu || is_imm)   {Grb, Rout, Yin} = '1;
        else if (is_md)         {Gra, Rout, Yin} = '1;
        else if (is_neg)        begin {Grb, Rout, Zin} = '1; OpCode = op_q; end
        else if (is_mem)        {Grb, BAout, Yin} = '1;
        else case (op_q)
          5'd19: {Gra, Rout, CONin} = '1;
          5'd20: begin {Gra, Rout, PCin} = '1; last = 1'b1; end
          5'd21: {PCout, Grb, Rin} = '1;
          5'd22: begin {InPortOut, Gra, Rin} = '1; last = 1'b1; end
          5'd23: begin {Gra, Rout, OutportIn} = '1; last = 1'b1; end
          5'd24: begin {HIout, Gra, Rin} = '1; last = 1'b1; end
          5'd25: begin {LOout, Gra, Rin} = '1; last = 1'b1; end
          5'd27: state_d = HALTED;
          default: last = 1'b1;
        endcase
      end
      T4: begin
        state_d = T5;
        if (is_alu)             begin {Grc, Rout, Zin} = '1; OpCode = op_q; end
        else if (is_imm)        begin {Cout, Zin} = '1; OpCode = op_q; end
        else if (is_md)         begin {Grb, Rout, Zin} = '1; OpCode = op_q; end
        else if (is_neg)        begin {Zlowout, Gra, Rin} = '1; last = 1'b1; end
        else if (is_mem)        begin {Cout, Zin} = '1; OpCode = OP_ADD; end
        else if (op_q == 5'd19) {PCout, Yin} = '1;
        else if (op_q == 5'd21) begin {Gra, Rout, PCin} = '1; last = 1'b1; end
        else                    last = 1'b1;
      end
      T5: begin
        state_d = T6;
        if (is_alu || is_imm || op_q == 5'd1) begin {Zlowout, Gra, Rin} = '1; last = 1'b1; end
        else if (is_md)         {Zlowout, LOin} = '1;
        else if (is_mem)        {Zlowout, MARin} = '1;
        else if (op_q == 5'd19) begin {Cout, Zin} = '1; OpCode = OP_ADD; end
        else                    last = 1'b1;
      end
      T6: begin
        if (is_md)              begin {Zhighout, HIin} = '1; last = 1'b1; end
        else if (op_q == 5'd0)  begin {Read, MDRin} = '1; if (wdone) state_d = T7; end
        else if (op_q == 5'd2)  begin {Gra, Rout, Write} = '1; last = wdone; end
        else if (op_q == 5'd19) begin {Zlowout, PCin} = {2{CON_FF}}; last = 1'b1; end
        else                    last = 1'b1;
      end
      T7: begin
        {MDRout, Gra, Rin} = '1; last = 1'b1;
      end
`ifdef CONTROL_SEQUENCER_STEP_EN
      PAUSED: begin
        if (Stop || stop_q) state_d = HALTED;
        else if (Step)      state_d = T0;
      end
`endif
      default: state_d = state_q;
    endcase
    if (last) state_d = bnd_next;
  end
endmodule
